iser_frame_data: RTL and testbench

- 2-lane LVDS ADC frame serializer: the transmit-side counterpart of the 2-lane deframer.
- Takes 16-bit sample words over a valid/ready handshake.
- Emits per-cycle 2-bit nibbles on two data lanes plus a matching 2-bit FCO pattern, MSB first, in 16-bit or 12-bit frame mode.
- Drives ADC-emulation loopback and deframer bring-up; its nibble outputs connect directly to the deframer nibble inputs in simulation and on test boards.

---
 rtl/iser_frame_data_if.sv | 21 ++
 rtl/iser_frame_data.sv | 203 ++++++++++++++++++++
 tb/tb_iser_frame_data.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/iser_frame_data_if.sv
// Sample stream and serial lane bundle for iser_frame_data.
// The master side supplies samples and observes lanes; the slave side is the serializer.
interface iser_frame_data_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  dout_nib_0;
  logic [1:0]  dout_nib_1;
  logic [1:0]  fco_nib;
  logic        frame_start;

  modport master (
    output s_data, s_valid,
    input  s_ready, dout_nib_0, dout_nib_1, fco_nib, frame_start
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, dout_nib_0, dout_nib_1, fco_nib, frame_start
  );
endinterface

// File: rtl/iser_frame_data.sv
// 2-lane LVDS ADC frame serializer: 16/12-bit words out as 2-bit nibbles per lane plus FCO.
// Optional ISER_FRAME_RAMP_EN adds a test_ramp input that transmits an internal counter.
module iser_frame_data #(
  parameter logic [15:0] IDLE_WORD   = 16'h0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           data_clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           sel_num_bits,
  input  logic           sel_bit_slip,
  input  logic           underflow_clr,
`ifdef ISER_FRAME_RAMP_EN
  input  logic           test_ramp,
`endif
  iser_frame_data_if.slave bus,
  output logic           underflow
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      st_q, st_d;
  logic [1:0]  cnt_q, cnt_d;
  // mode bit 1 = 12-bit frame, bit 0 = bit slip
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  sync_q [SYNC_STAGES];
  logic [1:0]  sync_mode;
  logic [7:0]  sh1_q, sh1_d, sh0_q, sh0_d;
  logic [1:0]  nib1_q, nib1_d, nib0_q, nib0_d, fco_q, fco_d;
  logic        fs_q, fs_d;
  logic [1:0]  carry_q, carry_d;
  logic        uf_q, uf_d;
  logic [1:0]  n_last;
  logic        boundary, ramp_on, slip_f, uf_set;
  logic [15:0] word;
  logic [1:0]  cur1, cur0;

`ifdef ISER_FRAME_RAMP_EN
  logic [15:0] ramp_q, ramp_d;
  assign ramp_on = test_ramp;
`else
  assign ramp_on = 1'b0;
`endif

  function automatic logic [1:0] fco_pat(input logic m12, input logic [1:0] c);
    if (m12) begin
      unique case (c)
        2'd0:    fco_pat = 2'b11;
        2'd1:    fco_pat = 2'b10;
        default: fco_pat = 2'b00;
      endcase
    end else begin
      fco_pat = (c < 2'd2) ? 2'b11 : 2'b00;
    end
  endfunction

  assign sync_mode = sync_q[SYNC_STAGES-1];
  assign n_last    = mode_q[1] ? 2'd2 : 2'd3;
  assign boundary  = (st_q == StRun) && enable && (cnt_q == n_last);

`ifdef ISER_FRAME_RAMP_EN
  assign word = ramp_on ? ramp_q : (bus.s_valid ? bus.s_data : IDLE_WORD);
`else
  assign word = bus.s_valid ? bus.s_data : IDLE_WORD;
`endif

  assign bus.s_ready     = boundary && !ramp_on;
  assign bus.dout_nib_1  = nib1_q;
  assign bus.dout_nib_0  = nib0_q;
  assign bus.fco_nib     = fco_q;
  assign bus.frame_start = fs_q;
  assign underflow       = uf_q;
  assign uf_set          = bus.s_ready && !bus.s_valid;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sh1_d   = sh1_q;
    sh0_d   = sh0_q;
    nib1_d  = 2'b00;
    nib0_d  = 2'b00;
    fco_d   = 2'b00;
    fs_d    = 1'b0;
    carry_d = carry_q;
    cur1    = 2'b00;
    cur0    = 2'b00;
    slip_f  = 1'b0;
`ifdef ISER_FRAME_RAMP_EN
    ramp_d  = ramp_q;
`endif
    unique case (st_q)
      StIdle: begin
        mode_d  = sync_mode;
        carry_d = 2'b00;
        cnt_d   = 2'd0;
        if (enable) begin
          st_d  = StRun;
          // Preamble cycle at the last count so the first accept happens next cycle
          cnt_d = sync_mode[1] ? 2'd2 : 2'd3;
        end
      end
      StRun: begin
        if (!enable) begin
          st_d    = StIdle;
          cnt_d   = 2'd0;
          carry_d = 2'b00;
          sh1_d   = 8'h00;
          sh0_d   = 8'h00;
`ifdef ISER_FRAME_RAMP_EN
          ramp_d  = 16'h0000;
`endif
        end else begin
          if (boundary) begin
            mode_d = sync_mode;
            if (sync_mode[1]) begin
              sh1_d = {word[15:10], 2'b00};
              sh0_d = {word[9:4], 2'b00};
            end else begin
              sh1_d = word[15:8];
              sh0_d = word[7:0];
            end
            cur1   = sh1_d[7:6];
            cur0   = sh0_d[7:6];
            sh1_d  = {sh1_d[5:0], 2'b00};
            sh0_d  = {sh0_d[5:0], 2'b00};
            cnt_d  = 2'd0;
            fs_d   = 1'b1;
            fco_d  = 2'b11;
            slip_f = sync_mode[0];
`ifdef ISER_FRAME_RAMP_EN
            if (ramp_on) ramp_d = ramp_q + (sync_mode[1] ? 16'h0010 : 16'h0001);
`endif
          end else begin
            cur1   = sh1_q[7:6];
            cur0   = sh0_q[7:6];
            sh1_d  = {sh1_q[5:0], 2'b00};
            sh0_d  = {sh0_q[5:0], 2'b00};
            cnt_d  = cnt_q + 2'd1;
            fco_d  = fco_pat(mode_q[1], cnt_d);
            slip_f = mode_q[0];
          end
          // Slip delays the data by one bit; the carried bit crosses frame boundaries
          nib1_d  = slip_f ? {carry_q[1], cur1[1]} : cur1;
          nib0_d  = slip_f ? {carry_q[0], cur0[1]} : cur0;
          carry_d = {cur1[0], cur0[0]};
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    uf_d = uf_q;
    if (uf_set)             uf_d = 1'b1;
    else if (underflow_clr) uf_d = 1'b0;
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
    end else begin
      sync_q[0] <= {sel_num_bits, sel_bit_slip};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      cnt_q   <= 2'd0;
      mode_q  <= 2'b00;
      sh1_q   <= 8'h00;
      sh0_q   <= 8'h00;
      nib1_q  <= 2'b00;
      nib0_q  <= 2'b00;
      fco_q   <= 2'b00;
      fs_q    <= 1'b0;
      carry_q <= 2'b00;
      uf_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sh1_q   <= sh1_d;
      sh0_q   <= sh0_d;
      nib1_q  <= nib1_d;
      nib0_q  <= nib0_d;
      fco_q   <= fco_d;
      fs_q    <= fs_d;
      carry_q <= carry_d;
      uf_q    <= uf_d;
    end
  end

`ifdef ISER_FRAME_RAMP_EN
  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) ramp_q <= 16'h0000;
    else        ramp_q <= ramp_d;
  end
`endif

endmodule

// File: tb/tb_iser_frame_data.sv
// Scoreboard bench for iser_frame_data: stimulus pushes expected frames, a negedge monitor
// pops one per frame_start and checks every nibble of it.
module tb_iser_frame_data;

  typedef struct packed {
    logic [7:0] l1;
    logic [7:0] l0;
    logic [7:0] fco;
    logic [2:0] len;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sel_num_bits = 1'b0;
  logic sel_bit_slip = 1'b0;
  logic underflow_clr = 1'b0;
  logic underflow;
`ifdef ISER_FRAME_RAMP_EN
  logic test_ramp = 1'b0;
`endif

  iser_frame_data_if bus ();

  iser_frame_data #(
    .IDLE_WORD  (16'h0000),
    .SYNC_STAGES(2)
  ) dut (
    .data_clk     (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sel_num_bits (sel_num_bits),
    .sel_bit_slip (sel_bit_slip),
    .underflow_clr(underflow_clr),
`ifdef ISER_FRAME_RAMP_EN
    .test_ramp    (test_ramp),
`endif
    .bus          (bus),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  frame_t exp_q[$];
  frame_t cur;
  int     n_checks = 0;
  int     n_errors = 0;
  int     rem = 0;
  int     idx = 0;
  int     accepts = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] l1, input logic [7:0] l0, input logic [7:0] fco,
                      input logic [2:0] len);
    frame_t f;
    f.l1 = l1; f.l0 = l0; f.fco = fco; f.len = len;
    exp_q.push_back(f);
  endtask

  // Monitor
  initial begin
    logic [6:0] got, want;
    int sh;
    forever begin
      @(negedge clk);
      got = {bus.frame_start, bus.dout_nib_1, bus.dout_nib_0, bus.fco_nib};
      if (rst_n && rem == 0) begin
        if (bus.frame_start) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 16'(got), 16'h0);
          end else begin
            cur = exp_q.pop_front();
            rem = int'(cur.len);
            idx = 0;
          end
        end else begin
          check("idle_outputs", 16'(got), 16'h0);
        end
      end
      if (rem > 0) begin
        sh   = 6 - 2 * idx;
        want = {(idx == 0), 2'(cur.l1 >> sh), 2'(cur.l0 >> sh), 2'(cur.fco >> sh)};
        check("frame_nibble", 16'(got), 16'(want));
        rem--;
        idx++;
      end
      if (bus.s_valid && bus.s_ready) accepts++;
    end
  end

  initial begin
    bus.s_data  = 16'h0000;
    bus.s_valid = 1'b0;
    cyc(2);
    check("reset_outputs", 16'({bus.frame_start, bus.dout_nib_1, bus.dout_nib_0, bus.fco_nib}),
          16'h0);
    check("reset_s_ready", 16'(bus.s_ready), 16'h0);
    check("reset_underflow", 16'(underflow), 16'h0);
    rst_n = 1'b1;
    cyc(2);

    // 16-bit, no slip, A5C3: three back-to-back frames
    bus.s_data = 16'hA5C3; bus.s_valid = 1'b1;
    repeat (3) push(8'b10_10_01_01, 8'b11_00_00_11, 8'b11_11_00_00, 3'd4);
    accepts = 0;
    enable = 1'b1;
    cyc(13);
    enable = 1'b0;
    cyc(1);
    check("a_disabled_outputs", 16'({bus.dout_nib_1, bus.dout_nib_0, bus.fco_nib}), 16'h0);
    check("a_accepts", 16'(accepts), 16'd3);

    // 12-bit, ABC0: three frames
    sel_num_bits = 1'b1;
    bus.s_data = 16'hABC0;
    cyc(4);
    repeat (3) push(8'b10_10_10_00, 8'b11_11_00_00, 8'b11_10_00_00, 3'd3);
    accepts = 0;
    enable = 1'b1;
    cyc(10);
    enable = 1'b0;
    cyc(1);
    check("b_accepts", 16'(accepts), 16'd3);

    // 16-bit with slip: FF00 then 0000, last bit of frame 0 spills into frame 1
    sel_num_bits = 1'b0; sel_bit_slip = 1'b1;
    bus.s_data = 16'hFF00;
    cyc(4);
    push(8'b01_11_11_11, 8'b00_00_00_00, 8'b11_11_00_00, 3'd4);
    push(8'b10_00_00_00, 8'b00_00_00_00, 8'b11_11_00_00, 3'd4);
    enable = 1'b1;
    cyc(2);
    bus.s_data = 16'h0000;
    cyc(7);
    enable = 1'b0;
    cyc(1);

    // Underflow with simultaneous clear, then a real word 1234
    sel_bit_slip = 1'b0;
    bus.s_valid = 1'b0;
    cyc(4);
    check("uf_before", 16'(underflow), 16'h0);
    push(8'h00, 8'h00, 8'b11_11_00_00, 3'd4);
    push(8'b00_01_00_10, 8'b00_11_01_00, 8'b11_11_00_00, 3'd4);
    underflow_clr = 1'b1;
    enable = 1'b1;
    cyc(2);
    check("uf_set_wins", 16'(underflow), 16'h1);
    underflow_clr = 1'b0;
    bus.s_data = 16'h1234; bus.s_valid = 1'b1;
    cyc(7);
    enable = 1'b0;
    cyc(1);
    check("uf_sticky", 16'(underflow), 16'h1);
    underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    check("uf_cleared", 16'(underflow), 16'h0);

    // Enable dropped at cnt=1, then re-enabled with a fresh word
    bus.s_data = 16'hA5C3;
    push(8'b10_10_00_00, 8'b11_00_00_00, 8'b11_11_00_00, 3'd2);
    push(8'b00_11_11_00, 8'b01_01_10_10, 8'b11_11_00_00, 3'd4);
    accepts = 0;
    enable = 1'b1;
    cyc(3);
    enable = 1'b0;
    bus.s_data = 16'h3C5A;
    cyc(1);
    check("drop_outputs_zero",
          16'({bus.frame_start, bus.dout_nib_1, bus.dout_nib_0, bus.fco_nib}), 16'h0);
    enable = 1'b1;
    cyc(1);
    check("reen_preamble_ready", 16'({bus.s_ready, bus.frame_start}), 16'b10);
    cyc(4);
    enable = 1'b0;
    cyc(1);
    check("drop_accepts", 16'(accepts), 16'd2);

    // Mode switch mid-frame: two 16-bit frames finish, then 12-bit frames
    bus.s_data = 16'hA5C3;
    repeat (2) push(8'b10_10_01_01, 8'b11_00_00_11, 8'b11_11_00_00, 3'd4);
    repeat (2) push(8'b10_10_01_00, 8'b01_11_00_00, 8'b11_10_00_00, 3'd3);
    accepts = 0;
    enable = 1'b1;
    cyc(4);
    sel_num_bits = 1'b1;
    cyc(11);
    enable = 1'b0;
    cyc(2);
    check("mode_accepts", 16'(accepts), 16'd4);
    check("queue_drained", 16'(exp_q.size() + rem), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
